nip_window_rx: RTL and testbench
================================

# nip_window_rx

Receiving end of the row-buffer column stream. Accepts one 40-bit pixel column per valid cycle from the BRAM row-buffer block and rebuilds the 5x5 neighbourhood window. Emits one windowed result per fully populated window position, tagged with its centre coordinates, and signals end of frame. It sits between the row-buffer block and downstream NIP kernels, and replaces the bench file dump as the in-fabric consumer.

## Interface
- IMG_W, 512, pixels per image row (columns per output row); minimum 5
- OUT_ROWS, 508, output rows per frame (IMG_H-4)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; arms a new frame from IDLE or DONE
- col_valid  in  1  col_in carries a column this cycle
- col_in  in  40  [39:32]=row r … [7:0]=row r+4, one column of 5 vertically adjacent pixels
- win_valid  out  1  win_* outputs valid this cycle
- win_sum  out  13  sum of the 25 window pixels (see Configuration)
- win_row  out  9  window centre output-row index, 0..OUT_ROWS-1
- win_col  out  9  window centre column, 2..IMG_W-3
- busy  out  1  high in FILL or STREAM
- done  out  1  high in DONE

## Operation
- States: IDLE, FILL, STREAM, DONE. Reset → IDLE.
- IDLE: col_valid ignored; start → FILL, clears col_cnt, row_cnt, and the window shift register.
- FILL: each valid column is shifted in and col_cnt increments. The 5th valid column of a row (col_cnt 4) → STREAM, and a window is produced for it.
- STREAM: every valid column produces a window. After the column with col_cnt = IMG_W-1:
  - col_cnt → 0, and the shift register and column sums are cleared.
  - row_cnt increments. Next state is FILL, or DONE if row_cnt was OUT_ROWS-1.
- DONE: done held high and columns ignored; start → FILL (new frame).
- Column handling:
  - No windows span a row boundary.
  - col_valid gaps are tolerated; counters advance only on valid columns.
  - start outside IDLE/DONE is ignored.
- Arithmetic:
  - Stage 1 forms a 11-bit column sum of the 5 bytes (max 1275).
  - Stage 2 keeps a running window sum: sum + colsum(new) − colsum(oldest), held at 13 bits (max 6375, no overflow).
  - The oldest column sum is taken from a 5-deep column-sum shift register, which is zero after a row clear.
- win_col = col_cnt of the newest column − 2. win_row = row_cnt at acceptance.

## Timing
- Reset values: win_valid 0, win_sum 0, win_row 0, win_col 0, busy 0, done 0; state IDLE.
- Latency: a column accepted at edge N yields win_valid/win_* after edge N+2 (two-stage pipeline). Fully pipelined, one window per cycle.
- win_* hold their last value when win_valid is 0.
- done rises one cycle after the last column is accepted, so the final window's win_valid (N+2) coincides with the 2nd done cycle. In-flight pipeline results are always flushed; the pipeline is never squashed by a state change.
- start in the same cycle as the DONE entry column is ignored.
- rst mid-frame: all outputs go to reset values immediately and in-flight windows are discarded.
- First window of each row: 5th valid column of that row plus 2 cycles.
- Frame: IMG_W−4 windows per row. Defaults give 508×508 = 258064 windows.

## Configuration
- NIP_WIN_SUM_EN defined: the stage-2 running sum is built and win_sum is the 25-pixel sum.
- NIP_WIN_SUM_EN undefined:
  - No sum adders or column-sum register.
  - win_sum = {5'b0, centre pixel}, i.e. byte [23:16] of the column accepted two valid columns before the newest.
  - Latency, win_valid, coordinates and state behaviour are identical.

## Test plan
- All columns 40'h0101010101, IMG_W=8, OUT_ROWS=2 → 4 windows per row with win_sum 25, win_col 2..5, win_row 0 then 1; then done=1 and busy=0.
- Column k = five bytes of value k (k=0..7) → win_sum = 5·(sum of 5 consecutive k): 50, 75, 100, 125. Without macro: win_sum 2, 3, 4, 5.
- All columns 40'hFFFFFFFFFF → win_sum 6375 (no wrap).
- col_valid toggled every other cycle → same win_sum sequence as contiguous; each win_valid 2 cycles after its triggering column.
- Assert rst for 1 cycle midway through row 1 → all outputs 0 and state IDLE; columns ignored until start; the next frame restarts at win_row 0, win_col 2.
- start pulsed during STREAM → no effect. start in DONE → new frame; the first window appears 5 columns + 2 cycles later.

Source files
------------

// File: rtl/nip_window_rx_if.sv
// Column-in / window-out bundle between the row-buffer reader and the window rebuilder.
// master drives columns and start; slave returns windows and status.
interface nip_window_rx_if;
  logic        start;
  logic        col_valid;
  logic [39:0] col_in;
  logic        win_valid;
  logic [12:0] win_sum;
  logic [8:0]  win_row;
  logic [8:0]  win_col;
  logic        busy;
  logic        done;

  modport master (
    output start, col_valid, col_in,
    input  win_valid, win_sum, win_row, win_col, busy, done
  );

  modport slave (
    input  start, col_valid, col_in,
    output win_valid, win_sum, win_row, win_col, busy, done
  );
endinterface

// File: rtl/nip_window_rx.sv
// nip_window_rx: rebuilds 5x5 windows from a column stream (IDLE -> FILL -> STREAM -> DONE).
// NIP_WIN_SUM_EN builds the 25-pixel running sum; otherwise win_sum carries the centre pixel.
module nip_window_rx #(
  parameter int IMG_W    = 512,
  parameter int OUT_ROWS = 508
) (
  input logic          clk,
  input logic          rst,
  nip_window_rx_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DONE} state_t;

  localparam logic [8:0] LAST_COL = 9'(IMG_W - 1);
  localparam logic [8:0] LAST_ROW = 9'(OUT_ROWS - 1);

  state_t      r_state, w_state_nxt;
  logic [8:0]  r_col_cnt, r_row_cnt;
  logic        w_acc, w_start_ok, w_last_col, w_last_row;

  logic        r_s1_vld, r_s1_emit;
  logic [8:0]  r_s1_row, r_s1_col;
  logic        r_s2_emit;
  logic [8:0]  r_s2_row, r_s2_col;
  logic [12:0] r_s2_sum;

  logic        r_win_valid;
  logic [12:0] r_win_sum;
  logic [8:0]  r_win_row, r_win_col;
  logic        r_busy, r_done;

  assign w_acc      = bus.col_valid && (r_state == S_FILL || r_state == S_STREAM);
  assign w_start_ok = bus.start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last_col = (r_col_cnt == LAST_COL);
  assign w_last_row = (r_row_cnt == LAST_ROW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) w_state_nxt = S_FILL;
      end
      S_FILL, S_STREAM: begin
        if (w_acc) begin
          if (w_last_col)             w_state_nxt = w_last_row ? S_DONE : S_FILL;
          else if (r_col_cnt == 9'd4) w_state_nxt = S_STREAM;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else if (w_start_ok) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else if (w_acc) begin
      if (w_last_col) begin
        r_col_cnt <= '0;
        r_row_cnt <= r_row_cnt + 9'd1;
      end else begin
        r_col_cnt <= r_col_cnt + 9'd1;
      end
    end
  end

  // Stage 1: tag every accepted column; only the 5th and later of a row emit a window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_emit <= 1'b0;
      r_s1_row  <= '0;
      r_s1_col  <= '0;
    end else begin
      r_s1_vld  <= w_acc;
      r_s1_emit <= w_acc && (r_col_cnt >= 9'd4);
      r_s1_row  <= r_row_cnt;
      r_s1_col  <= r_col_cnt - 9'd2;
    end
  end

`ifdef NIP_WIN_SUM_EN
  logic [10:0] w_colsum;
  logic [10:0] r_s1_cs;
  logic        r_s1_last;
  logic [10:0] r_cs_sr [5];
  logic [12:0] r_acc;
  logic [12:0] w_sum_nxt;

  assign w_colsum = 11'(bus.col_in[39:32]) + 11'(bus.col_in[31:24]) + 11'(bus.col_in[23:16])
                  + 11'(bus.col_in[15:8])  + 11'(bus.col_in[7:0]);
  // Modular 13-bit arithmetic is exact: the true result never exceeds 6375.
  assign w_sum_nxt = r_acc + 13'(r_s1_cs) - 13'(r_cs_sr[4]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_cs   <= '0;
      r_s1_last <= 1'b0;
    end else begin
      r_s1_cs   <= w_colsum;
      r_s1_last <= w_acc && w_last_col;
    end
  end

  // The row's last column still produces its window, then the history is wiped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_s2_sum <= '0;
      for (int i = 0; i < 5; i++) r_cs_sr[i] <= '0;
    end else if (r_s1_vld) begin
      r_s2_sum <= w_sum_nxt;
      if (r_s1_last) begin
        r_acc <= '0;
        for (int i = 0; i < 5; i++) r_cs_sr[i] <= '0;
      end else begin
        r_acc      <= w_sum_nxt;
        r_cs_sr[0] <= r_s1_cs;
        for (int i = 1; i < 5; i++) r_cs_sr[i] <= r_cs_sr[i-1];
      end
    end else if (w_start_ok) begin
      r_acc <= '0;
      for (int i = 0; i < 5; i++) r_cs_sr[i] <= '0;
    end
  end
`else
  logic [7:0] r_ctr0, r_ctr1, r_s1_pix;

  // r_ctr1 holds the centre byte of the column two valid columns behind the incoming one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctr0   <= '0;
      r_ctr1   <= '0;
      r_s1_pix <= '0;
    end else if (w_start_ok) begin
      r_ctr0 <= '0;
      r_ctr1 <= '0;
    end else if (w_acc) begin
      r_ctr0   <= bus.col_in[23:16];
      r_ctr1   <= r_ctr0;
      r_s1_pix <= r_ctr1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_s2_sum <= '0;
    else if (r_s1_vld) r_s2_sum <= {5'b0, r_s1_pix};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_emit <= 1'b0;
      r_s2_row  <= '0;
      r_s2_col  <= '0;
    end else begin
      r_s2_emit <= r_s1_emit;
      r_s2_row  <= r_s1_row;
      r_s2_col  <= r_s1_col;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_valid <= 1'b0;
      r_win_sum   <= '0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else begin
      r_win_valid <= r_s2_emit;
      if (r_s2_emit) begin
        r_win_sum <= r_s2_sum;
        r_win_row <= r_s2_row;
        r_win_col <= r_s2_col;
      end
    end
  end

  // Status lags the state by a cycle so the last window lands in the second done cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (r_state == S_FILL) || (r_state == S_STREAM);
      r_done <= (r_state == S_DONE);
    end
  end

  assign bus.win_valid = r_win_valid;
  assign bus.win_sum   = r_win_sum;
  assign bus.win_row   = r_win_row;
  assign bus.win_col   = r_win_col;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_nip_window_rx.sv
// Bench for nip_window_rx: directed vector table plus randomized frames against a window model.
module tb_nip_window_rx;
  localparam int W = 8;
  localparam int R = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nip_window_rx_if bus();

  nip_window_rx #(.IMG_W(W), .OUT_ROWS(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [12:0] sum;
    int          row;
    int          col;
    int          cyc;
  } win_t;

  win_t        exp_q[$];
  logic [12:0] obs_sum[$];
  int          obs_row[$];
  int          obs_col[$];

  bit          m_armed  = 0;
  bit          m_done   = 0;
  bit          exp_busy = 0;
  bit          exp_done = 0;
  int          m_col    = 0;
  int          m_row    = 0;
  logic [39:0] m_rowbuf [W];

  typedef struct packed {
    logic [1:0]       kind;
    logic [1:0]       gap;
    logic [3:0][12:0] exp;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Window value straight from the definition: the 25 bytes, or the centre byte.
  function automatic logic [12:0] ref_sum(int c);
    int s = 0;
`ifdef NIP_WIN_SUM_EN
    for (int k = c - 4; k <= c; k++)
      for (int b = 0; b < 5; b++)
        s += int'(m_rowbuf[k][b*8 +: 8]);
`else
    s = int'(m_rowbuf[c-2][23:16]);
`endif
    return 13'(s);
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_armed = 0; m_done = 0; exp_busy = 0; exp_done = 0;
      m_col = 0; m_row = 0;
      exp_q.delete();
    end else begin
      cyc++;
      exp_busy = m_armed;
      exp_done = m_done;
      if (!m_armed && bus.start) begin
        m_armed = 1; m_done = 0; m_col = 0; m_row = 0;
      end else if (m_armed && bus.col_valid) begin
        m_rowbuf[m_col] = bus.col_in;
        if (m_col >= 4) exp_q.push_back('{ref_sum(m_col), m_row, m_col - 2, cyc + 2});
        if (m_col == W - 1) begin
          m_col = 0;
          m_row++;
          if (m_row == R) begin
            m_armed = 0;
            m_done  = 1;
          end
        end else begin
          m_col++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("busy", 32'(bus.busy), 32'(exp_busy));
      check("done", 32'(bus.done), 32'(exp_done));
      if (bus.win_valid) begin : got_win
        win_t e;
        obs_sum.push_back(bus.win_sum);
        obs_row.push_back(int'(bus.win_row));
        obs_col.push_back(int'(bus.win_col));
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_window sum=%0d row=%0d col=%0d, none expected", bus.win_sum, bus.win_row, bus.win_col);
        end else begin
          e = exp_q.pop_front();
          check("win_sum", 32'(bus.win_sum), 32'(e.sum));
          check("win_row", 32'(bus.win_row), 32'(e.row));
          check("win_col", 32'(bus.win_col), 32'(e.col));
          check("win_latency", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic drive(input bit s, input bit v, input logic [39:0] d);
    @(negedge clk);
    bus.start     = s;
    bus.col_valid = v;
    bus.col_in    = d;
  endtask

  function automatic logic [39:0] colv(int kind, int c);
    logic [7:0] b;
    case (kind)
      0:       return 40'h01_0101_0101;
      1:       begin b = 8'(c); return {b, b, b, b, b}; end
      2:       return 40'hFF_FFFF_FFFF;
      default: return {8'($urandom), 32'($urandom)};
    endcase
  endfunction

  // gap: 0 contiguous, 1 alternate cycles, 2 random; start_at pulses start with that column
  task automatic send_row(input int kind, input int gap, input int start_at);
    for (int c = 0; c < W; c++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) drive(0, 0, colv(3, 0));
      drive(c == start_at, 1, colv(kind, c));
    end
  endtask

  task automatic finish_frame();
    int k = 0;
    while (!bus.done && k < 100) begin
      drive(0, 0, '0);
      k++;
    end
    check("frame_done", 32'(bus.done), 32'd1);
    repeat (3) drive(0, 1, 40'hFF_FFFF_FFFF);
    drive(0, 0, '0);
    check("done_hold", 32'(bus.done), 32'd1);
    check("busy_clear", 32'(bus.busy), 32'd0);
    check("flushed", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input int kind, input int gap, input int start_at);
    obs_sum.delete(); obs_row.delete(); obs_col.delete();
    drive(1, 0, '0);
    for (int r = 0; r < R; r++) send_row(kind, gap, (r == 0) ? start_at : -1);
    drive(0, 0, '0);
    finish_frame();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.start = 1'b0; bus.col_valid = 1'b0; bus.col_in = '0;

`ifdef NIP_WIN_SUM_EN
    tbl[0] = '{kind: 2'd0, gap: 2'd0, exp: {13'd25,   13'd25,   13'd25,   13'd25}};
    tbl[1] = '{kind: 2'd1, gap: 2'd0, exp: {13'd125,  13'd100,  13'd75,   13'd50}};
    tbl[2] = '{kind: 2'd2, gap: 2'd0, exp: {13'd6375, 13'd6375, 13'd6375, 13'd6375}};
    tbl[3] = '{kind: 2'd1, gap: 2'd1, exp: {13'd125,  13'd100,  13'd75,   13'd50}};
`else
    tbl[0] = '{kind: 2'd0, gap: 2'd0, exp: {13'd1,   13'd1,   13'd1,   13'd1}};
    tbl[1] = '{kind: 2'd1, gap: 2'd0, exp: {13'd5,   13'd4,   13'd3,   13'd2}};
    tbl[2] = '{kind: 2'd2, gap: 2'd0, exp: {13'd255, 13'd255, 13'd255, 13'd255}};
    tbl[3] = '{kind: 2'd1, gap: 2'd1, exp: {13'd5,   13'd4,   13'd3,   13'd2}};
`endif

    repeat (3) @(negedge clk);
    check("rst_win_valid", 32'(bus.win_valid), 32'd0);
    check("rst_win_sum",   32'(bus.win_sum),   32'd0);
    check("rst_win_row",   32'(bus.win_row),   32'd0);
    check("rst_win_col",   32'(bus.win_col),   32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    #2 rst = 1'b0;

    // columns offered in IDLE must not produce anything
    for (int i = 0; i < 6; i++) drive(0, 1, colv(1, i));
    drive(0, 0, '0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    for (int t = 0; t < 4; t++) begin
      run_frame(int'(tbl[t].kind), int'(tbl[t].gap), -1);
      check("tbl_count", 32'(obs_sum.size()), 32'(R * (W - 4)));
      for (int i = 0; i < obs_sum.size() && i < R * (W - 4); i++) begin
        check("tbl_sum", 32'(obs_sum[i]), 32'(tbl[t].exp[i % 4]));
        check("tbl_col", 32'(obs_col[i]), 32'(2 + i % 4));
        check("tbl_row", 32'(obs_row[i]), 32'(i / 4));
      end
    end

    // start during STREAM is ignored
    run_frame(1, 0, 5);
    check("stream_start_count", 32'(obs_sum.size()), 32'(R * (W - 4)));

    // start from DONE: first window two cycles after the 5th column
    obs_sum.delete(); obs_row.delete(); obs_col.delete();
    drive(1, 0, '0);
    for (int c = 0; c < 5; c++) drive(0, 1, colv(1, c));
    k = 0;
    do begin
      drive(0, 0, '0);
      k++;
    end while (!bus.win_valid && k < 10);
    check("restart_first_window_cycles", 32'(k), 32'd3);
    for (int c = 5; c < W; c++) drive(0, 1, colv(1, c));
    send_row(1, 0, -1);
    drive(0, 0, '0);
    finish_frame();

    // reset midway through row 1 with windows in flight
    drive(1, 0, '0);
    send_row(1, 0, -1);
    for (int c = 0; c < 6; c++) drive(0, 1, colv(1, c));
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_win_valid", 32'(bus.win_valid), 32'd0);
    check("mid_rst_win_sum",   32'(bus.win_sum),   32'd0);
    check("mid_rst_win_row",   32'(bus.win_row),   32'd0);
    check("mid_rst_win_col",   32'(bus.win_col),   32'd0);
    check("mid_rst_busy",      32'(bus.busy),      32'd0);
    check("mid_rst_done",      32'(bus.done),      32'd0);
    bus.col_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) drive(0, 1, colv(2, i));
    drive(0, 0, '0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    run_frame(1, 0, -1);
    check("post_rst_count", 32'(obs_sum.size()), 32'(R * (W - 4)));
    if (obs_sum.size() > 0) begin
      check("post_rst_first_row", 32'(obs_row[0]), 32'd0);
      check("post_rst_first_col", 32'(obs_col[0]), 32'd2);
    end

    // randomized frames: random pixels, random gaps, stray start pulses
    for (int f = 0; f < 8; f++) run_frame(3, 2, int'($urandom_range(0, W + 3)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
